// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - framebuffer write-port arbiter with timeout abort.
// Define FB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module fb_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_xpos,
  input  logic [NUM_REQ*8-1:0]       req_ypos,
  input  logic [NUM_REQ*8-1:0]       req_din,
  output logic [NUM_REQ-1:0]         req_ack,
  input  logic                       fb_rst_complete,
  output logic                       fb_we,
  output logic [7:0]                 fb_w_xpos,
  output logic [7:0]                 fb_w_ypos,
  output logic [7:0]                 fb_din,
  input  logic                       fb_w_data_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int          GW      = $clog2(NUM_REQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  state_t               state_q, state_d;
  logic                 fb_we_q, fb_we_d;
  logic [7:0]           xpos_q, xpos_d;
  logic [7:0]           ypos_q, ypos_d;
  logic [7:0]           din_q, din_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [15:0]          cnt_q, cnt_d;

  logic                 any_req;
  logic [GW-1:0]        win_idx;

`ifdef FB_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest valid index to the pointer wins.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = GW'((int'(rr_ptr_q) + off) % NUM_REQ);
      if (req_valid[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Pointer moves past the granted requester only when the write ends by ack or timeout.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_WRITE && state_d == ST_RELEASE) begin
      rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_req = 1'b1;
        win_idx = GW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    fb_we_d = fb_we_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    din_d   = din_q;
    ack_d   = '0;
    grant_d = grant_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_INIT: begin
        fb_we_d = 1'b0;
        cnt_d   = '0;
        if (fb_rst_complete) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!fb_rst_complete) begin
          state_d = ST_INIT;
        end else if (any_req) begin
          xpos_d  = req_xpos[8*win_idx +: 8];
          ypos_d  = req_ypos[8*win_idx +: 8];
          din_d   = req_din[8*win_idx +: 8];
          fb_we_d = 1'b1;
          grant_d = win_idx;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Acceptance is checked before the timeout so a last-cycle accept still acks.
        if (!fb_rst_complete) begin
          fb_we_d = 1'b0;
          state_d = ST_INIT;
        end else if (fb_w_data_valid) begin
          fb_we_d        = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = ST_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          fb_we_d = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        if (!fb_rst_complete)      state_d = ST_INIT;
        else if (!fb_w_data_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      fb_we_q <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      din_q   <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fb_we_q <= fb_we_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ack     = ack_q;
  assign fb_we       = fb_we_q;
  assign fb_w_xpos   = xpos_q;
  assign fb_w_ypos   = ypos_q;
  assign fb_din      = din_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb/tb_fb_write_arbiter.sv - scoreboard bench for fb_write_arbiter (honours FB_ARB_ROUND_ROBIN_EN).
module tb_fb_write_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;
  localparam int M_ACK   = 0;
  localparam int M_TO    = 1;
  localparam int M_RST   = 2;
  localparam int M_FBRST = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*8-1:0]   req_xpos, req_ypos, req_din;
  logic [NR-1:0]     req_ack;
  logic              fb_rst_complete;
  logic              fb_we;
  logic [7:0]        fb_w_xpos, fb_w_ypos, fb_din;
  logic              fb_w_data_valid;
  logic [1:0]        grant_id;
  logic              busy, timeout_err;

  typedef struct {
    int         id;
    logic [7:0] x, y, d;
    int         outcome;
    bit         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   last_grant = NR - 1;
  bit   err_sticky = 1'b0;

  always #5 clk = ~clk;

  fb_write_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_xpos(req_xpos),
    .req_ypos(req_ypos), .req_din(req_din), .req_ack(req_ack),
    .fb_rst_complete(fb_rst_complete), .fb_we(fb_we), .fb_w_xpos(fb_w_xpos),
    .fb_w_ypos(fb_w_ypos), .fb_din(fb_din), .fb_w_data_valid(fb_w_data_valid),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: scan requesters in priority order from the rules, not the RTL.
  function automatic int exp_winner(input logic [NR-1:0] v, input int last);
`ifdef FB_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
`else
    for (int i = 0; i < NR; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic new_payload(input int i);
    req_xpos[8*i +: 8] = 8'($urandom);
    req_ypos[8*i +: 8] = 8'($urandom);
    req_din[8*i +: 8]  = 8'($urandom);
  endtask

  task automatic add_req(input int i);
    if (!req_valid[i]) begin
      req_valid[i] = 1'b1;
      new_payload(i);
    end
  endtask

  task automatic check_reset();
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_xpos", int'(fb_w_xpos), 0);
    chk("rst_ypos", int'(fb_w_ypos), 0);
    chk("rst_din", int'(fb_din), 0);
    chk("rst_ack", int'(req_ack), 0);
    chk("rst_grant", int'(grant_id), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_err", int'(timeout_err), 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset();
    rst_n      = 1'b1;
    last_grant = NR - 1;
    err_sticky = 1'b0;
  endtask

  task automatic run_txn(input int mode, input int dly, input int hold, input bit keep);
    exp_t e;
    int   w, n, hi;
    if (req_valid == '0) add_req(int'($urandom_range(0, NR - 1)));
    w         = exp_winner(req_valid, last_grant);
    e.id      = w;
    e.x       = req_xpos[8*w +: 8];
    e.y       = req_ypos[8*w +: 8];
    e.d       = req_din[8*w +: 8];
    e.outcome = mode;
    e.err     = (mode == M_TO) ? 1'b1 : err_sticky;
    exp_q.push_back(e);
    n = 0;
    while (!fb_we && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("grant_within_bound", int'(fb_we), 1);
    if (!fb_we) return;
    case (mode)
      M_ACK: begin
        repeat (dly) begin @(posedge clk); #1; end
        fb_w_data_valid = 1'b1;
        @(posedge clk); #1;
        if (keep || $urandom_range(0, 1) == 1) new_payload(w);
        else req_valid[w] = 1'b0;
        last_grant = w;
        repeat (hold) begin
          @(posedge clk); #1;
          chk("release_hold_we", int'(fb_we), 0);
          chk("release_hold_busy", int'(busy), 1);
        end
        fb_w_data_valid = 1'b0;
        @(posedge clk); #1;
        chk("busy_after_release", int'(busy), 0);
      end
      M_TO: begin
        hi = 1;
        n  = 0;
        while (n < 100) begin
          @(posedge clk); #1;
          n++;
          if (!fb_we) break;
          hi++;
        end
        chk("timeout_we_cycles", hi, TO);
        chk("timeout_err_set", int'(timeout_err), 1);
        last_grant = w;
        err_sticky = 1'b1;
      end
      M_RST: begin
        repeat (dly) begin @(posedge clk); #1; end
        reset_pulse();
      end
      default: begin
        repeat (dly) begin @(posedge clk); #1; end
        fb_rst_complete = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
          chk("fbrst_we_low", int'(fb_we), 0);
          chk("fbrst_busy", int'(busy), 1);
        end
        fb_rst_complete = 1'b1;
      end
    endcase
  endtask

  // Monitor: pops an expectation whenever a write starts and checks it through completion.
  initial begin
    exp_t cur;
    bit   prev_we;
    prev_we = 1'b0;
    cur     = '{id: 0, x: 8'd0, y: 8'd0, d: 8'd0, outcome: M_ACK, err: 1'b0};
    forever begin
      @(negedge clk);
      if (fb_we && !prev_we) begin
        chk("grant_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("grant_id", int'(grant_id), cur.id);
          chk("grant_xpos", int'(fb_w_xpos), int'(cur.x));
          chk("grant_ypos", int'(fb_w_ypos), int'(cur.y));
          chk("grant_din", int'(fb_din), int'(cur.d));
        end
      end else if (fb_we) begin
        chk("hold_xpos", int'(fb_w_xpos), int'(cur.x));
        chk("hold_ypos", int'(fb_w_ypos), int'(cur.y));
        chk("hold_din", int'(fb_din), int'(cur.d));
        chk("hold_grant", int'(grant_id), cur.id);
      end
      if (!fb_we && prev_we) begin
        if (cur.outcome == M_ACK) begin
          chk("ack_onehot", int'(req_ack), 1 << cur.id);
          chk("ack_err", int'(timeout_err), int'(cur.err));
        end else if (cur.outcome == M_TO) begin
          chk("timeout_no_ack", int'(req_ack), 0);
          chk("timeout_err", int'(timeout_err), 1);
        end else begin
          chk("abort_no_ack", int'(req_ack), 0);
        end
      end else begin
        chk("ack_quiet", int'(req_ack), 0);
      end
      prev_we = fb_we;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    fb_rst_complete = 1'b0;
    fb_w_data_valid = 1'b0;
    req_valid       = '0;
    req_xpos        = '0;
    req_ypos        = '0;
    req_din         = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;

    // Framebuffer not ready: a pending request must not start a write.
    req_valid[0]       = 1'b1;
    req_xpos[7:0]      = 8'd5;
    req_ypos[7:0]      = 8'd3;
    req_din[7:0]       = 8'hFF;
    repeat (10) begin
      @(posedge clk); #1;
      chk("init_we_low", int'(fb_we), 0);
      chk("init_busy", int'(busy), 1);
    end
    fb_rst_complete = 1'b1;
    run_txn(M_ACK, 3, 0, 1'b0);

    // All requesters held and refreshed after each ack.
    req_valid = '0;
    reset_pulse();
    for (int i = 0; i < NR; i++) add_req(i);
    for (int k = 0; k < 5; k++) run_txn(M_ACK, int'($urandom_range(0, 3)), 0, 1'b1);

    run_txn(M_ACK, TO - 1, 0, 1'b0);
    run_txn(M_ACK, 1, 4, 1'b0);
    run_txn(M_TO, 0, 0, 1'b0);
    run_txn(M_ACK, 2, 1, 1'b0);
    run_txn(M_RST, 2, 0, 1'b0);
    run_txn(M_FBRST, 1, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int r;
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 2) == 0) add_req(i);
      end
      r = int'($urandom_range(0, 19));
      if (r == 0)      run_txn(M_TO, 0, 0, 1'b0);
      else if (r == 1) run_txn(M_RST, int'($urandom_range(0, 5)), 0, 1'b0);
      else if (r == 2) run_txn(M_FBRST, int'($urandom_range(0, 5)), 0, 1'b0);
      else             run_txn(M_ACK, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'b0);
    end

    req_valid = '0;
    repeat (10) @(posedge clk);
    #1;
    chk("final_busy", int'(busy), 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
